// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic {ST_IDLE, ST_ACK} arb_state_t;
    typedef enum logic {PORT_IB, PORT_DB} arb_port_t;

    localparam int unsigned WORD_LSB = 2;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = 4;

    // Map a one-hot {db, ib} grant vector to the winning port.
    function automatic arb_port_t grant_port(input logic [1:0] gnt);
        return gnt[1] ? PORT_DB : PORT_IB;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant {db, ib}.
// The last_grant state is held by the parent.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       req_ib_i,
    input  logic       req_db_i,
    input  arb_port_t  last_grant_i,
    output logic [1:0] gnt_c
);

    // On a tie the port that was not served last wins.
    always_comb begin
        gnt_c = 2'b00;
        if (req_ib_i && req_db_i) begin
            gnt_c = (last_grant_i == PORT_DB) ? 2'b01 : 2'b10;
        end else if (req_ib_i) begin
            gnt_c = 2'b01;
        end else if (req_db_i) begin
            gnt_c = 2'b10;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Wishbone-classic front end arbitrating an instruction-fetch port and a
// data port onto a single-port RAM with a one-cycle registered read.
// Each access is IDLE (RAM driven) followed by ACK (RAM data returned).
// Optional feature: define RAM_ARB_ERR_EN to range-check addresses against
// BASE_ADDR and terminate out-of-range accesses with err instead of ack.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // instruction port
    input  logic                  ib_cyc_i,
    input  logic                  ib_stb_i,
    input  logic [31:0]           ib_adr_i,
    output logic [31:0]           ib_dat_o,
    output logic                  ib_ack_o,
    output logic                  ib_err_o,
    // data port
    input  logic                  db_cyc_i,
    input  logic                  db_stb_i,
    input  logic                  db_we_i,
    input  logic [3:0]            db_sel_i,
    input  logic [31:0]           db_adr_i,
    input  logic [31:0]           db_dat_i,
    output logic [31:0]           db_dat_o,
    output logic                  db_ack_o,
    output logic                  db_err_o,
    // RAM macro
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_adr_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_dat_o,
    input  logic [31:0]           ram_dat_i
);

    localparam int unsigned HI_LSB = ADDR_WIDTH + WORD_LSB;

    arb_state_t state_q, state_d;
    arb_port_t  owner_q, owner_d;
    arb_port_t  last_grant_q, last_grant_d;
    logic       err_q, err_d;

    logic       req_ib_c, req_db_c;
    logic [1:0] gnt_c;
    logic       ib_oor_c, db_oor_c;
    logic       ib_term_c, db_term_c;
    logic       unused_c;

    assign req_ib_c = ib_cyc_i & ib_stb_i;
    assign req_db_c = db_cyc_i & db_stb_i;

`ifdef RAM_ARB_ERR_EN
    // Address bits above the RAM window must match the window base.
    assign ib_oor_c = (ib_adr_i[31:HI_LSB] != BASE_ADDR[31:HI_LSB]);
    assign db_oor_c = (db_adr_i[31:HI_LSB] != BASE_ADDR[31:HI_LSB]);
    assign unused_c = ^{ib_adr_i[1:0], db_adr_i[1:0]};
`else
    // No range check: the window aliases across the whole address space.
    assign ib_oor_c = 1'b0;
    assign db_oor_c = 1'b0;
    assign unused_c = ^{BASE_ADDR, ib_adr_i[31:HI_LSB], ib_adr_i[1:0],
                        db_adr_i[31:HI_LSB], db_adr_i[1:0]};
`endif

    rr_arb2 u_rr_arb2 (
        .req_ib_i     (req_ib_c),
        .req_db_i     (req_db_c),
        .last_grant_i (last_grant_q),
        .gnt_c        (gnt_c)
    );

    // Next-state, grant bookkeeping and combinational RAM drive.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        ram_we_o     = 1'b0;
        ram_adr_o    = '0;
        ram_be_o     = 4'h0;
        ram_dat_o    = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_c != 2'b00) begin
                    state_d      = ST_ACK;
                    owner_d      = grant_port(gnt_c);
                    last_grant_d = grant_port(gnt_c);
                end
                if (gnt_c[0]) begin
                    err_d     = ib_oor_c;
                    ram_adr_o = ib_adr_i[HI_LSB-1:WORD_LSB];
                    ram_be_o  = 4'hF;
                end else if (gnt_c[1]) begin
                    err_d     = db_oor_c;
                    ram_we_o  = db_we_i & ~db_oor_c;
                    ram_adr_o = db_adr_i[HI_LSB-1:WORD_LSB];
                    ram_be_o  = db_sel_i;
                    ram_dat_o = db_dat_i;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner, round-robin pointer and range-error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_IB;
            last_grant_q <= PORT_DB;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    // Termination is gated by the owner still holding its strobe.
    assign ib_term_c = (state_q == ST_ACK) && (owner_q == PORT_IB) && req_ib_c;
    assign db_term_c = (state_q == ST_ACK) && (owner_q == PORT_DB) && req_db_c;

    assign ib_ack_o = ib_term_c & ~err_q;
    assign db_ack_o = db_term_c & ~err_q;

`ifdef RAM_ARB_ERR_EN
    assign ib_err_o = ib_term_c & err_q;
    assign db_err_o = db_term_c & err_q;
`else
    assign ib_err_o = 1'b0;
    assign db_err_o = 1'b0;
`endif

    // Read data is only presented alongside ack.
    assign ib_dat_o = ib_ack_o ? ram_dat_i : 32'h0;
    assign db_dat_o = db_ack_o ? ram_dat_i : 32'h0;

endmodule
